uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL have these ports, one per line: name, direction, width, meaning.
- clk  input  1  single system clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- tick_16x  input  1  one-clk enable pulse at 16x the baud rate.
- rx_in  input  1  asynchronous serial line; idles high.
- i_fifo_full  input  1  downstream RX FIFO cannot accept a byte.
- rx_data  output  8  last received byte.
- rx_valid  output  1  one-clk pulse: rx_data holds a new byte; FIFO push strobe.
- frame_err  output  1  one-clk pulse: stop bit sampled low.
- overrun  output  1  one-clk pulse: byte dropped because i_fifo_full=1.
- o_rts_n  output  1  active-low Request-To-Send to the FTDI; low means "send".
- rx_busy  output  1  high while not in IDLE.

Function
REQ-002 rx_in SHALL pass through a 2-flop synchronizer before any use; all references to "line" below mean the synchronized value.
REQ-003 The FSM SHALL have the states IDLE, START, DATA and STOP, and SHALL advance only on clocks with tick_16x=1.
REQ-004 A 4-bit tick_count SHALL count 0..15 per bit period; the sample point is count 7.
REQ-005 In IDLE, on a tick with armed=1 and line=0, the FSM SHALL go to START with tick_count=1.
REQ-006 START, count 8: if the sampled start bit is 1 (false start), the FSM SHALL return to IDLE with no output pulse; otherwise it SHALL continue.
REQ-007 START, count 15: the FSM SHALL go to DATA with bit_index=0 and tick_count=0.
REQ-008 DATA: the bit sampled at count 7 SHALL shift in LSB first at count 15; after bit_index 7 the FSM SHALL go to STOP.
REQ-009 STOP, count 8: the FSM SHALL go to IDLE, so a following start edge one half-bit later is accepted (back-to-back frames).
REQ-010 STOP, count 8, stop bit = 1 and i_fifo_full = 0: rx_data SHALL load the shift register and rx_valid SHALL pulse on the next clk.
REQ-011 STOP, count 8, stop bit = 1 and i_fifo_full = 1: rx_data SHALL be unchanged and overrun SHALL pulse for one clk.
REQ-012 STOP, count 8, stop bit = 0: frame_err SHALL pulse for one clk, rx_data SHALL be unchanged, and armed SHALL clear.
REQ-013 armed SHALL set on any tick with line=1, which blocks repeated framing errors during a break condition.
REQ-014 o_rts_n SHALL be a registered copy of i_fifo_full, with one clk latency.
REQ-015 rx_valid, frame_err and overrun SHALL each be single-clk pulses and mutually exclusive.
REQ-016 rx_busy SHALL be registered, equal to (state != IDLE).

Reset
REQ-017 When rst=1 is sampled on a clk edge, the block SHALL force:
- state=IDLE, tick_count=0, bit_index=0, shift register=0
- rx_data=8'h00, rx_valid=0, frame_err=0, overrun=0, rx_busy=0
- o_rts_n=1, armed=0
- synchronizer flops=1
REQ-018 A reset mid-frame SHALL discard the partial byte with no output pulse; reception SHALL resume only after the line is seen high.

Configuration
REQ-019 With `UART_RX_MAJORITY_EN` defined, each bit value SHALL be the majority of samples at counts 6, 7 and 8.
REQ-020 Without `UART_RX_MAJORITY_EN`, each bit value SHALL be the single sample at count 7.
REQ-021 The decision counts (START/STOP at 8, DATA shift at 15) SHALL be identical in both builds.

Structure
REQ-022 A shared uart package/include SHALL hold:
- state encodings IDLE=0, START=1, DATA=2, STOP=3
- OVERSAMPLE=16, SAMPLE_PT=7, DATA_BITS=8
REQ-023 The synchronizer SHALL be a separate sub-module, uart_sync2 (1-bit, reset value 1), reusable for the CTS input path.

Verification
REQ-024 Frame 0xA5, 16 ticks/bit, i_fifo_full=0 -> rx_data=0xA5 and rx_valid=1 for exactly one clk; frame_err=0.
REQ-025 Low glitch of 4 ticks on an idle line -> no rx_valid, frame_err or overrun; rx_busy returns to 0 by tick 9.
REQ-026 Frame 0x3C with stop bit 0 -> frame_err pulses once; rx_data keeps its old value; line held low 40 bit times -> no further frame_err until the line goes high.
REQ-027 i_fifo_full=1 during frame 0x55 -> overrun pulses once, no rx_valid, o_rts_n=1 one clk after i_fifo_full rises.
REQ-028 Back-to-back frames 0x00, 0xFF with 1 stop bit, then rst asserted mid-frame of 0x81 -> exactly two rx_valid pulses (0x00, 0xFF), no pulse for 0x81, all outputs at reset values.
REQ-029 With `UART_RX_MAJORITY_EN`, a 1-tick inverted glitch at count 7 of data bit 3 of 0x0F -> rx_data=0x0F; without the macro -> rx_data=0x07.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared UART receiver definitions: FSM encoding, oversampling constants and bit-vote helper.
package uart_rx_pkg;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned SAMPLE_PT  = 7;
  localparam int unsigned DATA_BITS  = 8;
  localparam int unsigned CNT_W      = 4;
  localparam int unsigned IDX_W      = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for one asynchronous level input; resets to 1 (idle line / deasserted CTS).
module uart_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 16x oversampling 8N1 UART receiver with FIFO back-pressure (RTS) and break-safe framing errors.
// Define UART_RX_MAJORITY_EN to vote each bit over counts 6, 7 and 8 instead of sampling count 7 only.
module uart_rx
  import uart_rx_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_16x,
  input  logic       rx_in,
  input  logic       i_fifo_full,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       overrun,
  output logic       o_rts_n,
  output logic       rx_busy
);

  localparam logic [CNT_W-1:0] CNT_SAMPLE = CNT_W'(SAMPLE_PT);
  localparam logic [CNT_W-1:0] CNT_DECIDE = CNT_W'(SAMPLE_PT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DATA_BITS - 1);

  logic                 line;
  state_t               state;
  logic [CNT_W-1:0]     tick_count;
  logic [IDX_W-1:0]     bit_index;
  logic [DATA_BITS-1:0] shift;
  logic                 armed;
  logic                 s7;
  logic                 bit_val;
  logic                 bit_now;

  uart_sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx_in),
    .q   (line)
  );

`ifdef UART_RX_MAJORITY_EN
  localparam logic [CNT_W-1:0] CNT_EARLY = CNT_W'(SAMPLE_PT - 1);
  logic s6;

  always_ff @(posedge clk) begin
    if (rst) begin
      s6 <= 1'b0;
    end else if (tick_16x && tick_count == CNT_EARLY) begin
      s6 <= line;
    end
  end

  // Bit value is only consumed at the decision count, where line is the count-8 sample.
  assign bit_now = maj3(s6, s7, line);
`else
  assign bit_now = s7;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      tick_count <= '0;
      bit_index  <= '0;
      shift      <= '0;
      armed      <= 1'b0;
      s7         <= 1'b0;
      bit_val    <= 1'b0;
      rx_data    <= 8'h00;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      o_rts_n    <= 1'b1;
      rx_busy    <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      o_rts_n   <= i_fifo_full;

      if (tick_16x) begin
        // A framing error below overrides this so a held break cannot re-arm itself.
        if (line) armed <= 1'b1;
        if (tick_count == CNT_SAMPLE) s7 <= line;

        case (state)
          IDLE: begin
            if (armed && !line) begin
              state      <= START;
              tick_count <= CNT_W'(1);
              rx_busy    <= 1'b1;
            end
          end

          START: begin
            tick_count <= tick_count + CNT_W'(1);
            if (tick_count == CNT_DECIDE && bit_now) begin
              state      <= IDLE;
              tick_count <= '0;
              rx_busy    <= 1'b0;
            end else if (tick_count == CNT_LAST) begin
              state      <= DATA;
              bit_index  <= '0;
              tick_count <= '0;
            end
          end

          DATA: begin
            tick_count <= tick_count + CNT_W'(1);
            if (tick_count == CNT_DECIDE) bit_val <= bit_now;
            if (tick_count == CNT_LAST) begin
              tick_count <= '0;
              shift      <= {bit_val, shift[DATA_BITS-1:1]};
              bit_index  <= bit_index + IDX_W'(1);
              if (bit_index == IDX_LAST) state <= STOP;
            end
          end

          STOP: begin
            tick_count <= tick_count + CNT_W'(1);
            // Leave mid stop bit so a start edge half a bit later is caught.
            if (tick_count == CNT_DECIDE) begin
              state      <= IDLE;
              tick_count <= '0;
              rx_busy    <= 1'b0;
              if (!bit_now) begin
                frame_err <= 1'b1;
                armed     <= 1'b0;
              end else if (i_fifo_full) begin
                overrun <= 1'b1;
              end else begin
                rx_data  <= shift;
                rx_valid <= 1'b1;
              end
            end
          end

          default: begin
            state      <= IDLE;
            tick_count <= '0;
            rx_busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: one task per scenario, output pulses checked by a negedge monitor.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick_16x;
  logic       rx_in;
  logic       i_fifo_full;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       o_rts_n;
  logic       rx_busy;

  typedef struct packed {
    logic [1:0] kind;   // 0 = rx_valid, 1 = frame_err, 2 = overrun
    logic [7:0] data;   // rx_data expected while the pulse is high
  } exp_t;

  exp_t       exp_q[$];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] last_data = 8'h00;
  logic       prev_pulse = 1'b0;

  uart_rx dut (
    .clk         (clk),
    .rst         (rst),
    .tick_16x    (tick_16x),
    .rx_in       (rx_in),
    .i_fifo_full (i_fifo_full),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .frame_err   (frame_err),
    .overrun     (overrun),
    .o_rts_n     (o_rts_n),
    .rx_busy     (rx_busy)
  );

  always #5 clk = ~clk;

  // Output monitor: every pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      if (rx_valid || frame_err || overrun) begin
        exp_t       e;
        logic [1:0] kind;
        kind = rx_valid ? 2'd0 : (frame_err ? 2'd1 : 2'd2);
        checks++;
        if ($countones({rx_valid, frame_err, overrun}) != 1) begin
          errors++;
          $display("FAIL pulse_exclusive: valid/ferr/ovr=%b%b%b, required one-hot", rx_valid, frame_err, overrun);
        end
        checks++;
        if (prev_pulse) begin
          errors++;
          $display("FAIL pulse_width: pulse high on consecutive clocks, required single clock");
        end
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse: kind=%0d data=%h, required no pulse", kind, rx_data);
        end else begin
          e = exp_q.pop_front();
          if (kind !== e.kind || rx_data !== e.data) begin
            errors++;
            $display("FAIL event: kind=%0d data=%h, required kind=%0d data=%h", kind, rx_data, e.kind, e.data);
          end
        end
      end
      prev_pulse = rx_valid | frame_err | overrun;
    end else begin
      prev_pulse = 1'b0;
    end
  end

  // One oversample slot: line value applied, then a single tick pulse four clocks later.
  task automatic drive_slot(input logic v);
    rx_in = v;
    repeat (3) @(negedge clk);
    tick_16x = 1'b1;
    @(negedge clk);
    tick_16x = 1'b0;
  endtask

  task automatic idle_slots(input int n);
    for (int i = 0; i < n; i++) drive_slot(1'b1);
  endtask

  // Slots 0-15 start, 16-143 data LSB first, 144-159 stop; glitch inverts one slot.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input int glitch, input int nslots);
    for (int s = 0; s < nslots; s++) begin
      logic b;
      if (s < 16) b = 1'b0;
      else if (s < 144) b = d[3'((s - 16) / 16)];
      else b = stop_bit;
      if (s == glitch) b = ~b;
      drive_slot(b);
    end
  endtask

  task automatic check_queue_empty(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_missing: %0d expected pulses not seen, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if (rx_data !== 8'h00 || rx_valid !== 1'b0 || frame_err !== 1'b0 || overrun !== 1'b0 ||
        o_rts_n !== 1'b1 || rx_busy !== 1'b0) begin
      errors++;
      $display("FAIL %s: data=%h v=%b fe=%b ov=%b rts_n=%b busy=%b, required 00 0 0 0 1 0",
               name, rx_data, rx_valid, frame_err, overrun, o_rts_n, rx_busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; rx_in = 1'b1; tick_16x = 1'b0; i_fifo_full = 1'b0;
    repeat (4) @(negedge clk);
    check_reset_outputs("reset_values");
    rst = 1'b0;
    idle_slots(4);
    last_data = 8'h00;
  endtask

  task automatic test_frame();
    exp_q.push_back('{kind: 2'd0, data: 8'hA5});
    send_frame(8'hA5, 1'b1, -1, 160);
    last_data = 8'hA5;
    idle_slots(4);
    check_queue_empty("frame_a5");
    checks++;
    if (rx_data !== 8'hA5) begin
      errors++;
      $display("FAIL frame_a5_data: rx_data=%h, required a5", rx_data);
    end
  endtask

  task automatic test_glitch();
    for (int s = 0; s < 10; s++) begin
      drive_slot(s < 4 ? 1'b0 : 1'b1);
      if (s == 2) begin
        checks++;
        if (rx_busy !== 1'b1) begin
          errors++;
          $display("FAIL glitch_busy_high: rx_busy=%b, required 1", rx_busy);
        end
      end
    end
    checks++;
    if (rx_busy !== 1'b0 || rx_data !== last_data) begin
      errors++;
      $display("FAIL glitch_recover: rx_busy=%b rx_data=%h, required 0 %h", rx_busy, rx_data, last_data);
    end
    idle_slots(4);
  endtask

  task automatic test_frame_err();
    exp_q.push_back('{kind: 2'd1, data: last_data});
    send_frame(8'h3C, 1'b0, -1, 160);
    for (int i = 0; i < 40 * 16; i++) drive_slot(1'b0);
    check_queue_empty("frame_err");
    checks++;
    if (rx_busy !== 1'b0) begin
      errors++;
      $display("FAIL break_busy: rx_busy=%b during held break, required 0", rx_busy);
    end
    idle_slots(8);
    checks++;
    if (rx_data !== last_data) begin
      errors++;
      $display("FAIL frame_err_data: rx_data=%h, required %h", rx_data, last_data);
    end
  endtask

  task automatic test_overrun();
    checks++;
    if (o_rts_n !== 1'b0) begin
      errors++;
      $display("FAIL rts_before: o_rts_n=%b, required 0", o_rts_n);
    end
    i_fifo_full = 1'b1;
    @(negedge clk);
    checks++;
    if (o_rts_n !== 1'b1) begin
      errors++;
      $display("FAIL rts_after: o_rts_n=%b one clk after full, required 1", o_rts_n);
    end
    exp_q.push_back('{kind: 2'd2, data: last_data});
    send_frame(8'h55, 1'b1, -1, 160);
    i_fifo_full = 1'b0;
    idle_slots(4);
    check_queue_empty("overrun");
    checks++;
    if (rx_data !== last_data || o_rts_n !== 1'b0) begin
      errors++;
      $display("FAIL overrun_after: rx_data=%h o_rts_n=%b, required %h 0", rx_data, o_rts_n, last_data);
    end
  endtask

  task automatic test_back_to_back();
    exp_q.push_back('{kind: 2'd0, data: 8'h00});
    exp_q.push_back('{kind: 2'd0, data: 8'hFF});
    send_frame(8'h00, 1'b1, -1, 160);
    send_frame(8'hFF, 1'b1, -1, 160);
    send_frame(8'h81, 1'b1, -1, 80);
    check_queue_empty("back_to_back");
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_outputs("mid_frame_reset");
    rst = 1'b0;
    last_data = 8'h00;
    // Line still low after reset: must not start until seen high.
    for (int i = 0; i < 5; i++) drive_slot(1'b0);
    checks++;
    if (rx_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_rearm: rx_busy=%b with line low after reset, required 0", rx_busy);
    end
    idle_slots(6);
  endtask

  task automatic test_majority();
    logic [7:0] expd;
`ifdef UART_RX_MAJORITY_EN
    expd = 8'h0F;
`else
    expd = 8'h07;
`endif
    // Slot 71 is count 7 of data bit 3.
    exp_q.push_back('{kind: 2'd0, data: expd});
    send_frame(8'h0F, 1'b1, 71, 160);
    last_data = expd;
    idle_slots(4);
    check_queue_empty("majority");
    checks++;
    if (rx_data !== expd) begin
      errors++;
      $display("FAIL majority_data: rx_data=%h, required %h", rx_data, expd);
    end
  endtask

  initial begin
    rst = 1'b1; rx_in = 1'b1; tick_16x = 1'b0; i_fifo_full = 1'b0;
    @(negedge clk);
    test_reset();
    test_frame();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_back_to_back();
    test_majority();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
